sobel_window_scheduler: RTL and testbench
=========================================

# sobel_window_scheduler

Frame-scan controller that sequences the image ROM for the Sobel edge path. For every pixel of a 224x224 8-bit grayscale frame it fetches the 3x3 neighbourhood from the synchronous ROM and replicates border pixels by clamping coordinates. It presents the nine taps as one window, with a valid/ready handshake, to the downstream convolution/threshold stage. It replaces the free-running address counter so that convolution sees true 2-D neighbourhoods in raster order.

## Interface
- IMG_W, 224, frame width in pixels
- IMG_H, 224, frame height in pixels
- ADDR_W, 16, ROM address width (must satisfy 2^ADDR_W >= IMG_W*IMG_H)

- clk  in  1  single clock; all logic on posedge
- rst_n  in  1  reset, synchronous, active-low
- start  in  1  begin one frame scan; sampled only in IDLE
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse after the last window is accepted
- rom_addr  out  ADDR_W  ROM read address; ROM data returns 1 cycle later
- rom_data  in  8  ROM read data
- win_valid  out  1  window available
- win_ready  in  1  downstream accepts the window when valid&ready
- win_data  out  72  taps; tap k in bits [8k+7:8k]
- win_row  out  8  centre row of the presented window
- win_col  out  8  centre column of the presented window
- win_last  out  1  high with win_valid for the window at (IMG_H-1, IMG_W-1)

## Operation
- Tap index k = (dr+1)*3 + (dc+1), with dr, dc in {-1,0,1}; tap 4 is the centre pixel.
- Tap address = clamp(row+dr, 0, IMG_H-1)*IMG_W + clamp(col+dc, 0, IMG_W-1). No multiplier on the critical path is required; a running row-base register is acceptable.
- FSM states: IDLE, FETCH, LAST, PRESENT.
  - IDLE: start=1 -> FETCH with row=col=0 and tap counter=0. start=0 -> stay.
  - FETCH: drive the address of tap t = 0..8 on successive cycles. Capture rom_data as tap t-1 when t>=1. After t=8 -> LAST.
  - LAST: capture tap 8 -> PRESENT.
  - PRESENT: win_valid=1. On win_ready=1:
    - if (row,col) is the last pixel -> IDLE and pulse done;
    - else advance raster order (col+1; at col=IMG_W-1 wrap col to 0 and increment row) -> FETCH with tap counter=0.
  - PRESENT with win_ready=0: hold.
- While in PRESENT: win_data, win_row, win_col and win_last are stable, rom_addr is held, and no new fetch starts.
- start is ignored outside IDLE. A start in the same cycle as done is ignored; the block is in IDLE on the following cycle.
- Widths: coordinate counters are 8 bits; tap counter is 4 bits; clamp compares are unsigned on (coord-1) computed as 9-bit signed.

## Timing
- Reset values: busy=0, done=0, win_valid=0, win_last=0, rom_addr=0, win_data=0, win_row=0, win_col=0; state=IDLE.
- rst_n low mid-frame aborts the scan in the same clock edge. No done pulse is generated, and a new start is required.
- Start accepted at edge E:
  - busy=1 and first tap address on rom_addr after E;
  - win_valid rises 10 cycles after E (9 FETCH + 1 LAST).
- With win_ready held high, window throughput is 1 per 11 cycles. Full frame = IMG_W*IMG_H*11 cycles from start to done.
- done asserts in the cycle after the final handshake; busy falls in the same cycle.
- Taps must be captured exactly 1 cycle after their address is driven. Assumed ROM latency is 1; no other latency is supported.

## Test plan
- Reset: hold rst_n=0 with start=1 -> all outputs at reset values; busy stays 0.
- First window: ROM model data=addr[7:0], start pulse -> window (0,0). Taps 0..8 are 0x00,0x00,0x01,0x00,0x00,0x01,0xE0,0xE0,0xE1; win_valid rises 10 cycles after start.
- Interior window (5,5): taps are the bytes of addresses 900,901,902,1124,1125,1126,1348,1349,1350; win_col=5, win_row=5.
- Backpressure: win_ready=0 for 20 cycles at window (0,3) -> win_valid, win_data and rom_addr stay stable. Window (0,4) follows only after the handshake.
- Full frame with win_ready=1: 50176 windows in raster order. win_last is only on (223,223), whose taps 5, 7 and 8 read address 50175. There is one done pulse at cycle 551936 after start, and a start while busy has no effect.
- Reset mid-frame at window (100,50): outputs return to reset values within one edge; next start restarts at (0,0).

Source files
------------

// File: rtl/sobel_window_scheduler.sv
// rtl/sobel_window_scheduler.sv - 3x3 neighbourhood fetch scheduler for the Sobel edge path
// Walks the frame in raster order, reads nine clamped taps per pixel from a 1-cycle ROM.
module sobel_window_scheduler #(
  parameter int IMG_W  = 224,
  parameter int IMG_H  = 224,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [7:0]        rom_data,
  output logic              win_valid,
  input  logic              win_ready,
  output logic [71:0]       win_data,
  output logic [7:0]        win_row,
  output logic [7:0]        win_col,
  output logic              win_last
);

  localparam logic [7:0]        COL_LAST = 8'(IMG_W - 1);
  localparam logic [7:0]        ROW_LAST = 8'(IMG_H - 1);
  localparam logic [ADDR_W-1:0] W_STEP   = ADDR_W'(IMG_W);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_LAST, S_PRESENT} state_t;

  state_t            state_q, state_d;
  logic [7:0]        row_q, row_d;
  logic [7:0]        col_q, col_d;
  logic [3:0]        tap_q, tap_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic [71:0]       win_data_q, win_data_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              win_valid_q, win_valid_d;
  logic              win_last_q, win_last_d;
  logic              cap_en;
  logic [3:0]        cap_idx;
  logic              at_last;

  // base is row*IMG_W kept as a running register, so border clamping is just +/- one row step
  function automatic logic [ADDR_W-1:0] tap_addr(input logic [3:0] t, input logic [7:0] r,
                                                 input logic [7:0] c, input logic [ADDR_W-1:0] base);
    logic [ADDR_W-1:0] rb;
    logic [7:0]        cc;
    rb = base;
    if (t <= 4'd2 && r != 8'd0) rb = base - W_STEP;
    else if (t >= 4'd6 && r != ROW_LAST) rb = base + W_STEP;
    cc = c;
    if ((t == 4'd0 || t == 4'd3 || t == 4'd6) && c != 8'd0) cc = c - 8'd1;
    else if ((t == 4'd2 || t == 4'd5 || t == 4'd8) && c != COL_LAST) cc = c + 8'd1;
    return rb + ADDR_W'(cc);
  endfunction

  assign at_last = (row_q == ROW_LAST) && (col_q == COL_LAST);

  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    col_d       = col_q;
    tap_d       = tap_q;
    base_d      = base_q;
    rom_addr_d  = rom_addr_q;
    win_data_d  = win_data_q;
    win_valid_d = win_valid_q;
    win_last_d  = win_last_q;
    done_d      = 1'b0;
    cap_en      = 1'b0;
    cap_idx     = 4'd0;
    case (state_q)
      S_IDLE: begin
        // done_q blocks a start arriving in the same cycle as the completion pulse
        if (start && !done_q) begin
          state_d = S_FETCH;
          row_d   = 8'd0;
          col_d   = 8'd0;
          base_d  = '0;
          tap_d   = 4'd0;
        end
      end
      S_FETCH: begin
        cap_en  = (tap_q != 4'd0);
        cap_idx = tap_q - 4'd1;
        if (tap_q == 4'd8) state_d = S_LAST;
        else tap_d = tap_q + 4'd1;
      end
      S_LAST: begin
        cap_en      = 1'b1;
        cap_idx     = 4'd8;
        state_d     = S_PRESENT;
        win_valid_d = 1'b1;
        win_last_d  = at_last;
      end
      S_PRESENT: begin
        if (win_ready) begin
          win_valid_d = 1'b0;
          win_last_d  = 1'b0;
          if (at_last) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = S_FETCH;
            tap_d   = 4'd0;
            if (col_q == COL_LAST) begin
              col_d  = 8'd0;
              row_d  = row_q + 8'd1;
              base_d = base_q + W_STEP;
            end else begin
              col_d = col_q + 8'd1;
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    for (int k = 0; k < 9; k++) begin
      if (cap_en && cap_idx == 4'(k)) win_data_d[8*k +: 8] = rom_data;
    end
    if (state_d == S_FETCH) rom_addr_d = tap_addr(tap_d, row_d, col_d, base_d);
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      row_q       <= 8'd0;
      col_q       <= 8'd0;
      tap_q       <= 4'd0;
      base_q      <= '0;
      rom_addr_q  <= '0;
      win_data_q  <= 72'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      win_valid_q <= 1'b0;
      win_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      col_q       <= col_d;
      tap_q       <= tap_d;
      base_q      <= base_d;
      rom_addr_q  <= rom_addr_d;
      win_data_q  <= win_data_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      win_valid_q <= win_valid_d;
      win_last_q  <= win_last_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign rom_addr  = rom_addr_q;
  assign win_valid = win_valid_q;
  assign win_data  = win_data_q;
  assign win_row   = row_q;
  assign win_col   = col_q;
  assign win_last  = win_last_q;

endmodule

// File: tb/tb_sobel_window_scheduler.sv
// tb/tb_sobel_window_scheduler.sv - self-checking bench for sobel_window_scheduler
// Full-size instance for the fixed-geometry windows, a small instance for whole-frame scans.
module tb_sobel_window_scheduler;

  localparam int BW = 224;
  localparam int BH = 224;
  localparam int SW = 9;
  localparam int SH = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int chk_cnt = 0;
  int pass_cnt = 0;

  logic        b_rst_n, b_start, b_busy, b_done, b_win_valid, b_win_ready, b_win_last;
  logic [15:0] b_rom_addr;
  logic [7:0]  b_rom_data, b_win_row, b_win_col;
  logic [71:0] b_win_data;

  logic        s_rst_n, s_start, s_busy, s_done, s_win_valid, s_win_ready, s_win_last;
  logic [7:0]  s_rom_addr;
  logic [7:0]  s_rom_data, s_win_row, s_win_col;
  logic [71:0] s_win_data;

  logic [7:0]  mem_s [SW*SH];

  sobel_window_scheduler #(.IMG_W(BW), .IMG_H(BH), .ADDR_W(16)) dut (
    .clk(clk), .rst_n(b_rst_n), .start(b_start), .busy(b_busy), .done(b_done),
    .rom_addr(b_rom_addr), .rom_data(b_rom_data), .win_valid(b_win_valid),
    .win_ready(b_win_ready), .win_data(b_win_data), .win_row(b_win_row),
    .win_col(b_win_col), .win_last(b_win_last)
  );

  sobel_window_scheduler #(.IMG_W(SW), .IMG_H(SH), .ADDR_W(8)) dut_s (
    .clk(clk), .rst_n(s_rst_n), .start(s_start), .busy(s_busy), .done(s_done),
    .rom_addr(s_rom_addr), .rom_data(s_rom_data), .win_valid(s_win_valid),
    .win_ready(s_win_ready), .win_data(s_win_data), .win_row(s_win_row),
    .win_col(s_win_col), .win_last(s_win_last)
  );

  always @(posedge clk) b_rom_data <= b_rom_addr[7:0];
  always @(posedge clk) s_rom_data <= (int'(s_rom_addr) < SW*SH) ? mem_s[int'(s_rom_addr)] : 8'h00;

  function automatic int clampi(int v, int hi);
    return (v < 0) ? 0 : ((v > hi) ? hi : v);
  endfunction

  function automatic int big_addr(int k, int r, int c);
    return clampi(r + k / 3 - 1, BH - 1) * BW + clampi(c + k % 3 - 1, BW - 1);
  endfunction

  function automatic logic [7:0] big_tap(int k, int r, int c);
    return 8'(big_addr(k, r, c));
  endfunction

  function automatic logic [7:0] small_tap(int k, int r, int c);
    return mem_s[clampi(r + k / 3 - 1, SH - 1) * SW + clampi(c + k % 3 - 1, SW - 1)];
  endfunction

  task automatic test_reset;
    b_rst_n = 1'b0; s_rst_n = 1'b0;
    b_start = 1'b1; s_start = 1'b1;
    b_win_ready = 1'b0; s_win_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk_cnt++; if (b_busy !== 1'b0) $display("FAIL reset_busy: got %0b want 0", b_busy); else pass_cnt++;
    chk_cnt++; if (b_done !== 1'b0) $display("FAIL reset_done: got %0b want 0", b_done); else pass_cnt++;
    chk_cnt++; if (b_win_valid !== 1'b0) $display("FAIL reset_valid: got %0b want 0", b_win_valid); else pass_cnt++;
    chk_cnt++; if (b_win_last !== 1'b0) $display("FAIL reset_last: got %0b want 0", b_win_last); else pass_cnt++;
    chk_cnt++; if (b_rom_addr !== 16'd0) $display("FAIL reset_addr: got %0d want 0", b_rom_addr); else pass_cnt++;
    chk_cnt++; if (b_win_data !== 72'd0) $display("FAIL reset_data: got %h want 0", b_win_data); else pass_cnt++;
    chk_cnt++; if ({b_win_row, b_win_col} !== 16'd0) $display("FAIL reset_rowcol: got %0d,%0d want 0,0", b_win_row, b_win_col); else pass_cnt++;
    chk_cnt++;
    if ({s_busy, s_done, s_win_valid, s_win_last, s_rom_addr, s_win_data, s_win_row, s_win_col} !== '0)
      $display("FAIL reset_small: busy=%0b valid=%0b addr=%0d want all zero", s_busy, s_win_valid, s_rom_addr);
    else pass_cnt++;
    b_start = 1'b0; s_start = 1'b0;
    b_rst_n = 1'b1; s_rst_n = 1'b1;
    @(negedge clk);
    chk_cnt++; if (b_busy !== 1'b0) $display("FAIL busy_after_reset: got %0b want 0", b_busy); else pass_cnt++;
  endtask

  task automatic test_first_window;
    int cyc;
    @(negedge clk); b_start = 1'b1;
    @(negedge clk); b_start = 1'b0;
    cyc = 0;
    chk_cnt++; if (b_busy !== 1'b1) $display("FAIL first_busy: got %0b want 1", b_busy); else pass_cnt++;
    chk_cnt++; if (b_rom_addr !== 16'(big_addr(0, 0, 0))) $display("FAIL first_addr: got %0d want %0d", b_rom_addr, big_addr(0, 0, 0)); else pass_cnt++;
    while (!b_win_valid && cyc < 40) begin @(negedge clk); cyc++; end
    chk_cnt++; if (cyc != 10) $display("FAIL first_latency: got %0d want 10", cyc); else pass_cnt++;
    chk_cnt++; if ({b_win_row, b_win_col} !== 16'd0) $display("FAIL first_rowcol: got %0d,%0d want 0,0", b_win_row, b_win_col); else pass_cnt++;
    for (int k = 0; k < 9; k++) begin
      chk_cnt++;
      if (b_win_data[8*k +: 8] !== big_tap(k, 0, 0))
        $display("FAIL first_tap%0d: got %h want %h", k, b_win_data[8*k +: 8], big_tap(k, 0, 0));
      else pass_cnt++;
    end
    chk_cnt++; if (b_win_last !== 1'b0) $display("FAIL first_last: got %0b want 0", b_win_last); else pass_cnt++;
    b_win_ready = 1'b1;
    @(negedge clk);
    b_win_ready = 1'b0;
  endtask

  task automatic test_backpressure;
    int cyc;
    logic [71:0] held_data;
    logic [15:0] held_addr;
    int bad;
    for (int w = 1; w <= 3; w++) begin
      cyc = 0;
      while (!b_win_valid && cyc < 40) begin @(negedge clk); cyc++; end
      chk_cnt++;
      if (!b_win_valid || b_win_row !== 8'd0 || b_win_col !== 8'(w))
        $display("FAIL bp_window%0d: got valid=%0b at %0d,%0d want 0,%0d", w, b_win_valid, b_win_row, b_win_col, w);
      else pass_cnt++;
      if (w < 3) begin
        b_win_ready = 1'b1; @(negedge clk); b_win_ready = 1'b0;
      end
    end
    held_data = b_win_data;
    held_addr = b_rom_addr;
    chk_cnt++; if (held_addr !== 16'(big_addr(8, 0, 3))) $display("FAIL bp_held_addr: got %0d want %0d", held_addr, big_addr(8, 0, 3)); else pass_cnt++;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if ({b_win_valid, b_win_data, b_rom_addr, b_win_col} !== {1'b1, held_data, held_addr, 8'd3}) bad++;
    end
    chk_cnt++; if (bad != 0) $display("FAIL bp_stable: got %0d unstable cycles want 0", bad); else pass_cnt++;
    for (int k = 0; k < 9; k++) begin
      chk_cnt++;
      if (b_win_data[8*k +: 8] !== big_tap(k, 0, 3))
        $display("FAIL bp_tap%0d: got %h want %h", k, b_win_data[8*k +: 8], big_tap(k, 0, 3));
      else pass_cnt++;
    end
    b_win_ready = 1'b1; @(negedge clk); b_win_ready = 1'b0;
    cyc = 0;
    while (!b_win_valid && cyc < 40) begin @(negedge clk); cyc++; end
    chk_cnt++; if (cyc != 10) $display("FAIL bp_next_latency: got %0d want 10", cyc); else pass_cnt++;
    chk_cnt++; if ({b_win_row, b_win_col} !== {8'd0, 8'd4}) $display("FAIL bp_next_rowcol: got %0d,%0d want 0,4", b_win_row, b_win_col); else pass_cnt++;
  endtask

  task automatic test_interior;
    int cyc, er, ec, errs;
    bit found;
    er = 0; ec = 4; errs = 0; found = 1'b0; cyc = 0;
    while (cyc < 20000) begin
      if (b_win_valid) begin
        if (b_win_row !== 8'(er) || b_win_col !== 8'(ec)) errs++;
        if (er == 5 && ec == 5) begin b_win_ready = 1'b0; found = 1'b1; break; end
        b_win_ready = 1'b1;
        if (ec == BW - 1) begin ec = 0; er++; end else ec++;
      end else begin
        b_win_ready = 1'b0;
      end
      @(negedge clk); cyc++;
    end
    chk_cnt++; if (!found) $display("FAIL interior_timeout: got no window after %0d cycles want (5,5)", cyc); else pass_cnt++;
    chk_cnt++; if (errs != 0) $display("FAIL interior_order: got %0d out-of-order windows want 0", errs); else pass_cnt++;
    chk_cnt++; if ({b_win_row, b_win_col} !== {8'd5, 8'd5}) $display("FAIL interior_rowcol: got %0d,%0d want 5,5", b_win_row, b_win_col); else pass_cnt++;
    for (int k = 0; k < 9; k++) begin
      chk_cnt++;
      if (b_win_data[8*k +: 8] !== big_tap(k, 5, 5))
        $display("FAIL interior_tap%0d: got %h want %h", k, b_win_data[8*k +: 8], big_tap(k, 5, 5));
      else pass_cnt++;
    end
  endtask

  task automatic test_small_frame(input bit stalls);
    int n, widx, er, ec, errs, n_done;
    bit got_done;
    for (int i = 0; i < SW*SH; i++) mem_s[i] = 8'($urandom);
    errs = 0; widx = 0; er = 0; ec = 0; got_done = 1'b0; n_done = 0;
    @(negedge clk); s_start = 1'b1; s_win_ready = 1'b1;
    @(negedge clk); s_start = 1'b0;
    n = 0;
    while (n < 4000) begin
      if (s_done) begin got_done = 1'b1; n_done = n; break; end
      s_start = (n == 37);
      s_win_ready = stalls ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (s_win_last && !s_win_valid) errs++;
      if (s_win_valid) begin
        if (s_win_row !== 8'(er) || s_win_col !== 8'(ec)) errs++;
        if (s_win_last !== ((er == SH-1) && (ec == SW-1))) errs++;
        for (int k = 0; k < 9; k++) if (s_win_data[8*k +: 8] !== small_tap(k, er, ec)) errs++;
        if (s_win_ready) begin
          widx++;
          if (ec == SW - 1) begin ec = 0; er++; end else ec++;
        end
      end
      @(negedge clk); n++;
    end
    chk_cnt++; if (!got_done) $display("FAIL frame_done_timeout: got no done after %0d cycles", n); else pass_cnt++;
    chk_cnt++; if (widx != SW*SH) $display("FAIL frame_windows: got %0d want %0d", widx, SW*SH); else pass_cnt++;
    chk_cnt++; if (errs != 0) $display("FAIL frame_windows_content: got %0d errors want 0 (stalls=%0b)", errs, stalls); else pass_cnt++;
    if (!stalls) begin
      chk_cnt++; if (n_done != 11*SW*SH) $display("FAIL frame_cycles: got %0d want %0d", n_done, 11*SW*SH); else pass_cnt++;
    end
    chk_cnt++; if (s_busy !== 1'b0) $display("FAIL frame_busy_at_done: got %0b want 0", s_busy); else pass_cnt++;
    s_start = 1'b1;
    @(negedge clk);
    s_start = 1'b0;
    chk_cnt++;
    if ({s_busy, s_done} !== 2'b00) $display("FAIL start_with_done: got busy=%0b done=%0b want 0,0", s_busy, s_done);
    else pass_cnt++;
    repeat (3) @(negedge clk);
    chk_cnt++; if (s_busy !== 1'b0) $display("FAIL idle_after_done: got busy=%0b want 0", s_busy); else pass_cnt++;
  endtask

  task automatic test_reset_midframe;
    int cyc, widx, errs;
    bit hit;
    widx = 0; hit = 1'b0; cyc = 0;
    @(negedge clk); s_start = 1'b1; s_win_ready = 1'b1;
    @(negedge clk); s_start = 1'b0;
    while (cyc < 2000) begin
      if (s_win_valid) begin
        if (widx == 25) begin hit = 1'b1; break; end
        widx++;
      end
      @(negedge clk); cyc++;
    end
    chk_cnt++; if (!hit) $display("FAIL midreset_reach: got %0d windows want 25", widx); else pass_cnt++;
    s_rst_n = 1'b0;
    @(negedge clk);
    chk_cnt++;
    if ({s_busy, s_done, s_win_valid, s_win_last, s_rom_addr, s_win_data, s_win_row, s_win_col} !== '0)
      $display("FAIL midreset_outputs: busy=%0b valid=%0b addr=%0d row=%0d col=%0d want all zero",
               s_busy, s_win_valid, s_rom_addr, s_win_row, s_win_col);
    else pass_cnt++;
    @(negedge clk);
    s_rst_n = 1'b1;
    errs = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if ({s_busy, s_done, s_win_valid} !== 3'b000) errs++;
    end
    chk_cnt++; if (errs != 0) $display("FAIL midreset_stays_idle: got %0d active cycles want 0", errs); else pass_cnt++;
    s_start = 1'b1;
    @(negedge clk); s_start = 1'b0;
    cyc = 0;
    while (!s_win_valid && cyc < 40) begin @(negedge clk); cyc++; end
    chk_cnt++; if (cyc != 10) $display("FAIL midreset_restart_latency: got %0d want 10", cyc); else pass_cnt++;
    chk_cnt++; if ({s_win_row, s_win_col} !== 16'd0) $display("FAIL midreset_restart_rowcol: got %0d,%0d want 0,0", s_win_row, s_win_col); else pass_cnt++;
    errs = 0;
    for (int k = 0; k < 9; k++) if (s_win_data[8*k +: 8] !== small_tap(k, 0, 0)) errs++;
    chk_cnt++; if (errs != 0) $display("FAIL midreset_restart_taps: got %0d wrong taps want 0", errs); else pass_cnt++;
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_first_window();
    test_backpressure();
    test_interior();
    test_small_frame(1'b0);
    test_small_frame(1'b1);
    test_reset_midframe();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
